// File: rtl/mem_1r1w_masked_rdport_pkg.sv
// Shared widths and the per-lane merge used to fold same-cycle writes into read data.
package mem_1r1w_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_MASK_GRAN  = 8;
    localparam int RSP_DEPTH      = 3;
    localparam int MAX_DATA_WIDTH = 512;

    function automatic int mask_width(input int data_width, input int gran);
        return data_width / gran;
    endfunction

    localparam int DEF_MASK_WIDTH = mask_width(DEF_DATA_WIDTH, DEF_MASK_GRAN);

    typedef logic [MAX_DATA_WIDTH-1:0] word_t;

    // Callers zero-extend into word_t; gran is a constant at every call site so
    // the bit-to-lane division folds away.
    function automatic word_t lane_merge(input word_t old_word, input word_t new_word,
                                         input word_t mask, input int gran);
        word_t res;
        for (int b = 0; b < MAX_DATA_WIDTH; b++)
            res[b] = mask[b / gran] ? new_word[b] : old_word[b];
        return res;
    endfunction

endpackage

// File: rtl/mem_1r1w_masked_rdport_if.sv
// Request/response stream between a read client and the memory read-port front end.
interface mem_1r1w_masked_rdport_if import mem_1r1w_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mem_1r1w_masked_rdport_fifo.sv
// 3-entry response FIFO; head is read straight from storage registers, pointers wrap mod 3.
module mem_rsp_fifo import mem_1r1w_pkg::*; #(
    parameter int WIDTH = DEF_DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             head_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic [1:0]       count_q;
    logic             pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(RSP_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign head_valid = (count_q != 2'd0);
    assign head_data  = mem_q[rd_ptr];
    assign count      = count_q;
    assign pop        = head_valid && head_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= push_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mem_1r1w_masked_rdport.sv
// Valid/ready read front end for the 1R1W byte-masked macro, with write-before-read bypass.
module mem_1r1w_masked_rdport import mem_1r1w_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MASK_GRAN  = DEF_MASK_GRAN,
    parameter int MASK_WIDTH = mask_width(DATA_WIDTH, MASK_GRAN)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    mem_1r1w_masked_rdport_if.slave rd,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_mask,
    output logic [ADDR_WIDTH-1:0] R0_addr,
    output logic                  R0_en,
    output logic                  R0_clk,
    input  logic [DATA_WIDTH-1:0] R0_data,
    output logic [ADDR_WIDTH-1:0] W0_addr,
    output logic                  W0_en,
    output logic                  W0_clk,
    output logic [DATA_WIDTH-1:0] W0_data,
    output logic [MASK_WIDTH-1:0] W0_mask
);
    logic                  acc;
    logic [1:0]            fifo_count;
    logic [2:0]            credits_used;
    logic                  inflight;
    logic [MASK_WIDTH-1:0] byp_mask;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] merged;

    assign W0_clk  = clock;
    assign W0_en   = wr_en;
    assign W0_addr = wr_addr;
    assign W0_data = wr_data;
    assign W0_mask = wr_mask;

    // Credits count both buffered and in-flight reads, so the FIFO can never overflow
    // and req_ready never depends on rsp_ready.
    assign credits_used = {1'b0, fifo_count} + {2'b00, inflight};
    assign rd.req_ready = (credits_used < 3'(RSP_DEPTH));
    assign acc          = rd.req_valid && rd.req_ready && reset_n;

    assign R0_clk  = clock;
    assign R0_en   = acc;
    assign R0_addr = rd.req_addr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= 1'b0;
            byp_mask <= '0;
            byp_data <= '0;
        end else begin
            inflight <= acc;
            if (acc) begin
                byp_mask <= (wr_en && wr_addr == rd.req_addr) ? wr_mask : '0;
                byp_data <= wr_data;
            end
        end
    end

    // The macro's collision result is undefined, so masked lanes come from the captured write.
    assign merged = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(R0_data), MAX_DATA_WIDTH'(byp_data),
                                           MAX_DATA_WIDTH'(byp_mask), MASK_GRAN));

    mem_rsp_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (inflight),
        .push_data  (merged),
        .head_ready (rd.rsp_ready),
        .head_valid (rd.rsp_valid),
        .head_data  (rd.rsp_data),
        .count      (fifo_count)
    );
endmodule

// File: tb/tb_mem_1r1w_masked_rdport.sv
// Directed + random bench: macro model with undefined collisions, scoreboard from a plain reference memory.
module tb_mem_1r1w_masked_rdport;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int MW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] wr_mask = '0;
    logic [AW-1:0] R0_addr;
    logic          R0_en;
    logic          R0_clk;
    logic [DW-1:0] R0_data = '0;
    logic [AW-1:0] W0_addr;
    logic          W0_en;
    logic          W0_clk;
    logic [DW-1:0] W0_data;
    logic [MW-1:0] W0_mask;

    always #5 clock = ~clock;

    mem_1r1w_masked_rdport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rd_if ();

    mem_1r1w_masked_rdport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_GRAN(8)) dut (
        .clock(clock), .reset_n(reset_n), .rd(rd_if),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_clk(R0_clk), .R0_data(R0_data),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_clk(W0_clk), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    // Memory macro: 1-cycle read; lanes written in the same cycle read back as garbage.
    logic [DW-1:0] macro_mem [32];
    always @(posedge clock) begin
        logic [DW-1:0] r;
        if (R0_en) begin
            r = macro_mem[R0_addr];
            if (W0_en && W0_addr == R0_addr)
                for (int l = 0; l < MW; l++) if (W0_mask[l]) r[l*8 +: 8] = 8'($urandom);
            R0_data <= r;
        end
        if (W0_en)
            for (int l = 0; l < MW; l++)
                if (W0_mask[l]) macro_mem[W0_addr][l*8 +: 8] <= W0_data[l*8 +: 8];
    end

    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            outstanding = 0;
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_q [$];
    logic          s_acc, s_pop, s_req_ready, s_rsp_valid;
    logic [DW-1:0] s_rsp_data;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: settle, sample, update the reference model, then advance to the next negedge.
    task automatic tick();
        #1;
        s_req_ready = rd_if.req_ready;
        s_rsp_valid = rd_if.rsp_valid;
        s_rsp_data  = rd_if.rsp_data;
        s_acc = rd_if.req_valid && s_req_ready && reset_n;
        s_pop = s_rsp_valid && rd_if.rsp_ready;
        if (s_pop) begin
            if (exp_q.size() == 0) check("rsp_valid_unexpected", 64'(s_rsp_valid), 64'd0);
            else check("rsp_data", s_rsp_data, exp_q.pop_front());
            outstanding--;
        end
        if (wr_en)
            for (int l = 0; l < MW; l++)
                if (wr_mask[l]) ref_mem[wr_addr][l*8 +: 8] = wr_data[l*8 +: 8];
        if (s_acc) begin
            exp_q.push_back(ref_mem[rd_if.req_addr]);
            outstanding++;
            check("no_overflow", 64'(outstanding <= 3), 64'd1);
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic idle();
        rd_if.req_valid = 1'b0;
        rd_if.rsp_ready = 1'b1;
        wr_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [MW-1:0] m);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_mask = m;
    endtask

    initial begin
        int n, first_pop, last_pop, pops;
        logic ready_dropped;
        rd_if.req_valid = 1'b0;
        rd_if.req_addr  = '0;
        rd_if.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        #2 reset_n = 1'b0;
        @(negedge clock);

        // Reset state, with a read attempt and write pass-through held during reset
        rd_if.req_valid = 1'b1;
        rd_if.req_addr  = 5'd3;
        wr(9, 64'hDEAD_BEEF_0BAD_F00D, 8'h00);
        #1;
        check("rst_rsp_valid", 64'(rd_if.rsp_valid), 64'd0);
        check("rst_rsp_data", rd_if.rsp_data, 64'd0);
        check("rst_req_ready", 64'(rd_if.req_ready), 64'd1);
        check("rst_r0_en", 64'(R0_en), 64'd0);
        check("rst_w0_pass", {W0_data[31:0], 23'd0, W0_en, W0_mask, 3'd0, W0_addr},
              {32'h0BAD_F00D, 23'd0, 1'b1, 8'h00, 3'd0, 5'd9});
        check("clk_pass", 64'({R0_clk, W0_clk}), 64'({clock, clock}));
        rd_if.req_valid = 1'b0;

        // Preload every word through the write port while still in reset
        for (int i = 0; i < 32; i++) begin
            wr(i, (i == 3) ? 64'h1111_2222_3333_4444 : (i == 5) ? 64'd0 : {$urandom, $urandom}, 8'hFF);
            tick();
        end
        idle();
        reset_n = 1'b1;
        tick();

        // Single read: latency exactly 2
        rd_if.req_valid = 1'b1; rd_if.req_addr = 5'd3;
        tick();
        check("t1_accept", 64'(s_acc), 64'd1);
        idle();
        tick();
        check("t1_lat_early", 64'(s_rsp_valid), 64'd0);
        tick();
        check("t1_lat", 64'(s_rsp_valid), 64'd1);
        check("t1_data", s_rsp_data, 64'h1111_2222_3333_4444);
        tick();

        // Back-to-back sweep with random concurrent writes
        pops = 0; first_pop = -1; last_pop = -1; ready_dropped = 1'b0;
        for (int i = 0; i < 36; i++) begin
            rd_if.req_valid = (i < 32);
            rd_if.req_addr  = AW'(i);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, 31));
            wr_data = {$urandom, $urandom};
            wr_mask = 8'($urandom);
            tick();
            if (i < 32 && !s_req_ready) ready_dropped = 1'b1;
            if (s_pop) begin
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                pops++;
            end
        end
        idle();
        check("b2b_ready_held", 64'(ready_dropped), 64'd0);
        check("b2b_pops", 64'(pops), 64'd32);
        check("b2b_consecutive", 64'(last_pop - first_pop), 64'd31);

        // Same-cycle collision with a partial mask
        wr(5, 64'd0, 8'hFF);
        tick();
        rd_if.req_valid = 1'b1; rd_if.req_addr = 5'd5;
        wr(5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        tick();
        idle();
        tick();
        tick();
        check("collide_valid", 64'(s_rsp_valid), 64'd1);
        check("collide_data", s_rsp_data, 64'h0000_0000_FFFF_FFFF);

        // Backpressure: 3 credits, then recovery one cycle after the first pop
        rd_if.rsp_ready = 1'b0; rd_if.req_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            rd_if.req_addr = AW'($urandom_range(0, 31));
            tick();
            n += int'(s_acc);
        end
        check("bp_accepts", 64'(n), 64'd3);
        check("bp_ready_low", 64'(s_req_ready), 64'd0);
        rd_if.rsp_ready = 1'b1;
        tick();
        check("bp_pop_no_acc", 64'({s_pop, s_acc}), 64'b10);
        tick();
        check("bp_acc_after_pop", 64'(s_acc), 64'd1);
        idle();
        for (int i = 0; i < 5; i++) tick();

        // Write one cycle after the read is accepted is not reflected
        wr(7, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
        tick();
        wr_en = 1'b0; rd_if.req_valid = 1'b1; rd_if.req_addr = 5'd7;
        tick();
        rd_if.req_valid = 1'b0;
        wr(7, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF);
        tick();
        idle();
        tick();
        check("late_write_data", s_rsp_data, 64'hA5A5_A5A5_A5A5_A5A5);
        tick();

        // Reset with two buffered and one in flight
        rd_if.rsp_ready = 1'b0; rd_if.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_if.req_addr = AW'(i + 10);
            tick();
        end
        rd_if.req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 64'(rd_if.rsp_valid), 64'd0);
        check("midrst_req_ready", 64'(rd_if.req_ready), 64'd1);
        exp_q.delete();
        outstanding = 0;
        tick();
        tick();
        reset_n = 1'b1;
        rd_if.rsp_ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pops += int'(s_pop);
        end
        check("midrst_ready_after", 64'(s_req_ready), 64'd1);
        check("midrst_no_stale", 64'(pops), 64'd0);

        // Random traffic with frequent collisions
        for (int i = 0; i < 400; i++) begin
            rd_if.req_valid = ($urandom_range(0, 3) != 0);
            rd_if.req_addr  = AW'($urandom_range(0, 7));
            rd_if.rsp_ready = ($urandom_range(0, 2) != 0);
            wr_en   = ($urandom_range(0, 1) == 1);
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = {$urandom, $urandom};
            wr_mask = 8'($urandom);
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
